register_status_tracker: RTL and testbench

Per-register hazard scoreboard for the 16-entry architectural register file, the producer side of the runahead instruction queue's status inputs. Tracks which registers await a long-latency (load) writeback (dirty), which await a pipelined ALU writeback (to-be-written), and how many deferred readers sit in the runahead queue (to-be-read). It drives `DirtyVector`, `ToBeWrittenVector` and `ToBeReadVector`, and raises `Stalled` for the fetch/issue stage.

---
 rtl/register_status_tracker.sv | 171 +++++++++++++++++
 tb/tb_register_status_tracker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_status_tracker.sv
// Per-register hazard scoreboard for the 16-entry register file.
// Tracks pending load writebacks (dirty), pending ALU writebacks
// (to-be-written) and the number of deferred readers parked in the runahead
// queue (to-be-read). Register 0 is hardwired zero and is never tracked.
module register_status_tracker #(
    parameter int RUNAHEADDEPTH     = 32,
    parameter int READCOUNTBITWIDTH = $clog2(2 * RUNAHEADDEPTH + 1)
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic        IssueValid,
    input  logic [3:0]  IssueDestReg,
    input  logic        IssueDestWrites,
    input  logic        IssueDestIsLoad,
    input  logic        DeferValid,
    input  logic [3:0]  DeferAReg,
    input  logic [3:0]  DeferBReg,
    input  logic        DeferAReads,
    input  logic        DeferBReads,
    input  logic        ReleaseValid,
    input  logic [3:0]  ReleaseAReg,
    input  logic [3:0]  ReleaseBReg,
    input  logic        ReleaseAReads,
    input  logic        ReleaseBReads,
    input  logic        LoadWritebackValid,
    input  logic [3:0]  LoadWritebackReg,
    input  logic        AluWritebackValid,
    input  logic [3:0]  AluWritebackReg,
    input  logic [3:0]  IssueSrcA,
    input  logic [3:0]  IssueSrcB,
    output logic [15:0] DirtyVector,
    output logic [15:0] ToBeWrittenVector,
    output logic [15:0] ToBeReadVector,
    output logic        Stalled,
    output logic        TrackerError
);

    localparam int              CW      = READCOUNTBITWIDTH;
    localparam logic [CW-1:0]   CNT_MAX = CW'(2 * RUNAHEADDEPTH);

    // One-hot decode of a register index; bit 0 is always dropped because
    // events aimed at register 0 are ignored.
    function automatic logic [15:0] reg_hot(input logic valid, input logic [3:0] idx);
        logic [15:0] hot;
        if (valid) begin
            hot = 16'h0001 << idx;
        end else begin
            hot = 16'h0000;
        end
        reg_hot = hot & 16'hFFFE;
    endfunction

    // Number of sources (0..2) of a defer/release pair naming register idx.
    function automatic logic [1:0] src_hits(
        input logic       valid,
        input logic       a_reads,
        input logic [3:0] a_reg,
        input logic       b_reads,
        input logic [3:0] b_reg,
        input logic [3:0] idx
    );
        logic a_hit;
        logic b_hit;
        a_hit    = valid && a_reads && (a_reg == idx);
        b_hit    = valid && b_reads && (b_reg == idx);
        src_hits = {1'b0, a_hit} + {1'b0, b_hit};
    endfunction

    // Net counter update in one step. Returns {error, new_count}: an
    // underflow clamps to 0, an overflow saturates at CNT_MAX.
    function automatic logic [CW:0] count_step(
        input logic [CW-1:0] cnt,
        input logic [1:0]    inc,
        input logic [1:0]    dec
    );
        logic [CW+1:0] up;
        logic [CW+1:0] down;
        logic [CW+1:0] val;
        up   = {2'b00, cnt} + (CW+2)'(inc);
        down = (CW+2)'(dec);
        val  = {(CW+2){1'b0}};
        if (down > up) begin
            count_step = {1'b1, {CW{1'b0}}};
        end else begin
            val = up - down;
            if (val > {2'b00, CNT_MAX}) begin
                count_step = {1'b1, CNT_MAX};
            end else begin
                count_step = {1'b0, val[CW-1:0]};
            end
        end
    endfunction

    logic [15:0]   dirty_r;
    logic [15:0]   tbw_r;
    logic [15:0]   tbr_r;
    logic [CW-1:0] cnt_r [16];
    logic          err_r;

    logic [15:0]   issue_load_hot_s;
    logic [15:0]   issue_alu_hot_s;
    logic [15:0]   lwb_hot_s;
    logic [15:0]   awb_hot_s;
    logic [15:0]   dirty_next_s;
    logic [15:0]   tbw_next_s;
    logic          wb_err_s;

    logic [CW-1:0] cnt_next_s [16];
    logic [15:0]   tbr_next_s;
    logic          cnt_err_s;
    logic [CW:0]   step_s;

    // Writeback-pending bits: a new producer in the same cycle beats the clear.
    always_comb begin
        issue_load_hot_s = reg_hot(IssueValid && IssueDestWrites && IssueDestIsLoad, IssueDestReg);
        issue_alu_hot_s  = reg_hot(IssueValid && IssueDestWrites && !IssueDestIsLoad, IssueDestReg);
        lwb_hot_s        = reg_hot(LoadWritebackValid, LoadWritebackReg);
        awb_hot_s        = reg_hot(AluWritebackValid, AluWritebackReg);
        dirty_next_s     = (dirty_r & ~lwb_hot_s) | issue_load_hot_s;
        tbw_next_s       = (tbw_r & ~awb_hot_s) | issue_alu_hot_s;
        wb_err_s         = (|(lwb_hot_s & ~dirty_r)) | (|(awb_hot_s & ~tbw_r));
    end

    // Pending-read counters: defers and releases of one cycle net out together.
    always_comb begin
        cnt_err_s     = 1'b0;
        step_s        = {(CW+1){1'b0}};
        tbr_next_s    = 16'h0000;
        cnt_next_s[0] = {CW{1'b0}};
        for (int i = 1; i < 16; i++) begin
            step_s = count_step(
                cnt_r[i],
                src_hits(DeferValid, DeferAReads, DeferAReg, DeferBReads, DeferBReg, 4'(i)),
                src_hits(ReleaseValid, ReleaseAReads, ReleaseAReg, ReleaseBReads, ReleaseBReg, 4'(i))
            );
            cnt_next_s[i] = step_s[CW-1:0];
            tbr_next_s[i] = (step_s[CW-1:0] != {CW{1'b0}});
            cnt_err_s     = cnt_err_s | step_s[CW];
        end
    end

    // State register: async clear, all updates gated by the clock enable.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            dirty_r <= 16'h0000;
            tbw_r   <= 16'h0000;
            tbr_r   <= 16'h0000;
            err_r   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else if (clk_en) begin
            dirty_r <= dirty_next_s;
            tbw_r   <= tbw_next_s;
            tbr_r   <= tbr_next_s;
            err_r   <= err_r | cnt_err_s | wb_err_s;
            for (int i = 0; i < 16; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign DirtyVector       = dirty_r;
    assign ToBeWrittenVector = tbw_r;
    assign ToBeReadVector    = tbr_r;
    assign TrackerError      = err_r;
    // Register 0 never has its to-be-written bit set, so it never stalls.
    assign Stalled           = tbw_r[IssueSrcA] | tbw_r[IssueSrcB];

endmodule

// File: tb/tb_register_status_tracker.sv
// Scoreboard bench for register_status_tracker: a driver issues one event
// set per cycle and queues the expected next state; monitors pop and compare.
module tb_register_status_tracker;

    localparam int DEPTH = 32;
    localparam int MAXC  = 2 * DEPTH;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic        IssueValid, IssueDestWrites, IssueDestIsLoad;
    logic [3:0]  IssueDestReg;
    logic        DeferValid, DeferAReads, DeferBReads;
    logic [3:0]  DeferAReg, DeferBReg;
    logic        ReleaseValid, ReleaseAReads, ReleaseBReads;
    logic [3:0]  ReleaseAReg, ReleaseBReg;
    logic        LoadWritebackValid, AluWritebackValid;
    logic [3:0]  LoadWritebackReg, AluWritebackReg;
    logic [3:0]  IssueSrcA, IssueSrcB;
    logic [15:0] DirtyVector, ToBeWrittenVector, ToBeReadVector;
    logic        Stalled, TrackerError;

    register_status_tracker #(.RUNAHEADDEPTH(DEPTH)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
        .IssueValid(IssueValid), .IssueDestReg(IssueDestReg),
        .IssueDestWrites(IssueDestWrites), .IssueDestIsLoad(IssueDestIsLoad),
        .DeferValid(DeferValid), .DeferAReg(DeferAReg), .DeferBReg(DeferBReg),
        .DeferAReads(DeferAReads), .DeferBReads(DeferBReads),
        .ReleaseValid(ReleaseValid), .ReleaseAReg(ReleaseAReg), .ReleaseBReg(ReleaseBReg),
        .ReleaseAReads(ReleaseAReads), .ReleaseBReads(ReleaseBReads),
        .LoadWritebackValid(LoadWritebackValid), .LoadWritebackReg(LoadWritebackReg),
        .AluWritebackValid(AluWritebackValid), .AluWritebackReg(AluWritebackReg),
        .IssueSrcA(IssueSrcA), .IssueSrcB(IssueSrcB),
        .DirtyVector(DirtyVector), .ToBeWrittenVector(ToBeWrittenVector),
        .ToBeReadVector(ToBeReadVector), .Stalled(Stalled), .TrackerError(TrackerError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv; logic [3:0] idst; logic iw; logic il;
        logic       dv; logic [3:0] da; logic [3:0] db; logic dar; logic dbr;
        logic       rv; logic [3:0] ra; logic [3:0] rb; logic rar; logic rbr;
        logic       lv; logic [3:0] lr; logic av; logic [3:0] ar;
        logic [3:0] sa; logic [3:0] sb; logic en;
    } stim_t;

    typedef struct {
        logic [15:0] d; logic [15:0] w; logic [15:0] r; logic e;
    } exp_t;

    exp_t state_q[$];
    logic stall_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: plain per-register flags and integer read counts.
    bit m_dirty[16];
    bit m_tbw[16];
    int m_cnt[16];
    bit m_err;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{iv: 1'b0, idst: 4'd0, iw: 1'b0, il: 1'b0,
              dv: 1'b0, da: 4'd0, db: 4'd0, dar: 1'b0, dbr: 1'b0,
              rv: 1'b0, ra: 4'd0, rb: 4'd0, rar: 1'b0, rbr: 1'b0,
              lv: 1'b0, lr: 4'd0, av: 1'b0, ar: 4'd0,
              sa: 4'd0, sb: 4'd0, en: 1'b1};
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_dirty[i] = 1'b0; m_tbw[i] = 1'b0; m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.d[i] = m_dirty[i];
            e.w[i] = m_tbw[i];
            e.r[i] = (m_cnt[i] != 0);
        end
        e.e = m_err;
        return e;
    endfunction

    function automatic void model_update(input stim_t s);
        int delta[16];
        for (int i = 0; i < 16; i++) delta[i] = 0;
        if (s.dv && s.dar) delta[s.da] += 1;
        if (s.dv && s.dbr) delta[s.db] += 1;
        if (s.rv && s.rar) delta[s.ra] -= 1;
        if (s.rv && s.rbr) delta[s.rb] -= 1;
        for (int i = 1; i < 16; i++) begin
            int n;
            n = m_cnt[i] + delta[i];
            if (n < 0) begin
                n = 0; m_err = 1'b1;
            end else if (n > MAXC) begin
                n = MAXC; m_err = 1'b1;
            end
            m_cnt[i] = n;
        end
        if (s.lv && s.lr != 4'd0) begin
            if (!m_dirty[s.lr]) m_err = 1'b1;
            m_dirty[s.lr] = 1'b0;
        end
        if (s.av && s.ar != 4'd0) begin
            if (!m_tbw[s.ar]) m_err = 1'b1;
            m_tbw[s.ar] = 1'b0;
        end
        if (s.iv && s.iw && s.idst != 4'd0) begin
            if (s.il) m_dirty[s.idst] = 1'b1;
            else      m_tbw[s.idst]   = 1'b1;
        end
    endfunction

    task automatic drive(input stim_t s);
        IssueValid = s.iv; IssueDestReg = s.idst; IssueDestWrites = s.iw; IssueDestIsLoad = s.il;
        DeferValid = s.dv; DeferAReg = s.da; DeferBReg = s.db; DeferAReads = s.dar; DeferBReads = s.dbr;
        ReleaseValid = s.rv; ReleaseAReg = s.ra; ReleaseBReg = s.rb; ReleaseAReads = s.rar; ReleaseBReads = s.rbr;
        LoadWritebackValid = s.lv; LoadWritebackReg = s.lr;
        AluWritebackValid = s.av; AluWritebackReg = s.ar;
        IssueSrcA = s.sa; IssueSrcB = s.sb; clk_en = s.en;
    endtask

    // One cycle of stimulus; expectations go to the scoreboard queues.
    task automatic step(input stim_t s);
        @(negedge clk);
        drive(s);
        stall_q.push_back(m_tbw[s.sa] || m_tbw[s.sb]);
        if (s.en) model_update(s);
        state_q.push_back(model_view());
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.sa = 4'd3; s.sb = 4'd5;
        @(negedge clk);
        drive(s);
        #3 async_rst_n = 1'b0;
        #1;
        check("rst_dirty", DirtyVector, 16'h0000);
        check("rst_tbw", ToBeWrittenVector, 16'h0000);
        check("rst_tbr", ToBeReadVector, 16'h0000);
        check("rst_err", {15'd0, TrackerError}, 16'h0000);
        check("rst_stall", {15'd0, Stalled}, 16'h0000);
        model_reset();
        @(negedge clk);
        #3 async_rst_n = 1'b1;
    endtask

    // State monitor: compares registered outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                check("dirty", DirtyVector, e.d);
                check("tbw", ToBeWrittenVector, e.w);
                check("tbr", ToBeReadVector, e.r);
                check("err", {15'd0, TrackerError}, {15'd0, e.e});
            end
        end
    end

    // Stall monitor: Stalled is combinational from state and current sources.
    initial begin
        logic x;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                x = stall_q.pop_front();
                check("stalled", {15'd0, Stalled}, {15'd0, x});
            end
        end
    end

    initial begin
        stim_t s;
        async_rst_n = 1'b0;
        drive(idle());
        model_reset();
        do_reset();

        // Issue of a load to register 0 is ignored.
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.il = 1'b1; s.idst = 4'd0; step(s);
        step(idle());

        // Load lifecycle on reg 5.
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.il = 1'b1; s.idst = 4'd5; step(s);
        repeat (3) step(idle());
        s = idle(); s.lv = 1'b1; s.lr = 4'd5; step(s);
        repeat (2) step(idle());

        // Set beats clear on reg 3, then stall on source A.
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.idst = 4'd3; step(s);
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.idst = 4'd3; s.av = 1'b1; s.ar = 4'd3; step(s);
        s = idle(); s.sa = 4'd3; step(s);
        s = idle(); s.sa = 4'd4; step(s);
        s = idle(); s.av = 1'b1; s.ar = 4'd3; s.sb = 4'd3; step(s);
        s = idle(); s.sb = 4'd3; step(s);

        // Read counting on reg 7: 2, 3, 2, 1, 0.
        s = idle(); s.dv = 1'b1; s.da = 4'd7; s.db = 4'd7; s.dar = 1'b1; s.dbr = 1'b1; step(s);
        s = idle(); s.dv = 1'b1; s.da = 4'd7; s.dar = 1'b1; step(s);
        s = idle(); s.rv = 1'b1; s.ra = 4'd7; s.rb = 4'd7; s.rar = 1'b1; s.rbr = 1'b1;
        s.dv = 1'b1; s.db = 4'd7; s.dbr = 1'b1; step(s);
        s = idle(); s.rv = 1'b1; s.ra = 4'd7; s.rar = 1'b1; step(s);
        step(s);
        step(idle());

        // Clock enable: nothing moves while low, then same events take effect.
        s = idle(); s.en = 1'b0; s.iv = 1'b1; s.iw = 1'b1; s.il = 1'b1; s.idst = 4'd6;
        s.dv = 1'b1; s.da = 4'd6; s.dar = 1'b1; step(s); step(s);
        s.en = 1'b1; step(s);
        step(idle());

        // Saturation on reg 9: 65 increments then 64 decrements.
        do_reset();
        s = idle(); s.dv = 1'b1; s.da = 4'd9; s.db = 4'd9; s.dar = 1'b1; s.dbr = 1'b1;
        repeat (DEPTH) step(s);
        s.dbr = 1'b0; step(s);
        s = idle(); s.rv = 1'b1; s.ra = 4'd9; s.rb = 4'd9; s.rar = 1'b1; s.rbr = 1'b1;
        repeat (DEPTH) step(s);
        step(idle());

        // Underflow on reg 2.
        do_reset();
        s = idle(); s.rv = 1'b1; s.ra = 4'd2; s.rar = 1'b1; step(s);
        step(idle());

        // Spurious writebacks: load to clean reg, ALU to clean reg, and reg 0.
        do_reset();
        s = idle(); s.av = 1'b1; s.ar = 4'd0; s.lv = 1'b1; s.lr = 4'd0; step(s);
        s = idle(); s.lv = 1'b1; s.lr = 4'd4; step(s);
        do_reset();
        s = idle(); s.av = 1'b1; s.ar = 4'd8; step(s);
        step(idle());

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.en   = ($urandom_range(0, 7) != 0);
            s.iv   = 1'($urandom); s.iw = 1'($urandom); s.il = 1'($urandom); s.idst = 4'($urandom);
            s.dv   = 1'($urandom); s.da = 4'($urandom); s.db = 4'($urandom);
            s.dar  = 1'($urandom); s.dbr = 1'($urandom);
            s.rv   = ($urandom_range(0, 3) == 0); s.ra = 4'($urandom); s.rb = 4'($urandom);
            s.rar  = 1'($urandom); s.rbr = 1'($urandom);
            s.lv   = ($urandom_range(0, 3) == 0); s.lr = 4'($urandom);
            s.av   = ($urandom_range(0, 3) == 0); s.ar = 4'($urandom);
            s.sa   = 4'($urandom); s.sb = 4'($urandom);
            step(s);
        end
        step(idle());

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && (state_q.size() > 0 || stall_q.size() > 0); k++) @(posedge clk);
        #3;
        compared++;
        if (state_q.size() != 0 || stall_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d state and %0d stall expectations left, required 0",
                     state_q.size(), stall_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
